// File: rtl/alu_in_responder_core_pkg.sv
// rtl/alu_in_responder_core_pkg.sv - opcodes, exec states, FIFO entry type and ALU helper
package alu_core_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } alu_in_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC1,
        S_MULW,
        S_FLUSH
    } exec_state_t;

    // op is kept as raw bits so the undefined codes 101/110 survive the FIFO
    typedef struct packed {
        logic [2:0]       op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_in_entry_t;

    function automatic logic op_has_result(input logic [2:0] op);
        return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
    endfunction

    function automatic logic [2*ALU_W-1:0] alu_eval(input logic [2:0] op,
                                                     input logic [ALU_W-1:0] a,
                                                     input logic [ALU_W-1:0] b);
        case (op)
            add_op:  return (2*ALU_W)'(a) + (2*ALU_W)'(b);
            and_op:  return (2*ALU_W)'(a & b);
            xor_op:  return (2*ALU_W)'(a ^ b);
            mul_op:  return (2*ALU_W)'(a) * (2*ALU_W)'(b);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_in_responder_core_if.sv
// rtl/alu_in_responder_core_if.sv - alu_in bus between initiator and responder core
interface alu_in_responder_core_if #(parameter int W = 8);
    logic           valid;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*W-1:0] result;
    logic           busy;

    modport master (output valid, op, a, b, input ready, done, result, busy);
    modport slave  (input valid, op, a, b, output ready, done, result, busy);
endinterface

// File: rtl/alu_in_sync_fifo.sv
// rtl/alu_in_sync_fifo.sv - in-order transfer buffer with synchronous clear
module alu_in_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_count_next,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    // a push into a full buffer only lands when a pop frees the slot on the same edge
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_comb begin
        o_count_next = r_count + CW'(w_push) - CW'(w_pop);
        if (i_clr) o_count_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= o_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/alu_in_responder_core.sv
// rtl/alu_in_responder_core.sv - alu_in responder: buffers transfers and executes them in order
module alu_in_responder_core
    import alu_core_pkg::*;
#(
    parameter int ALU_IN_OP_WIDTH = ALU_W,
    parameter int FIFO_DEPTH      = 4,
    parameter int MUL_LATENCY     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_rst,
    alu_in_responder_core_if.slave  bus
);
    localparam int W   = ALU_IN_OP_WIDTH;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int MCW = $clog2(MUL_LATENCY + 1);

    alu_in_entry_t  w_din;
    alu_in_entry_t  w_head;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_next;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_finish;
    logic           w_flush;
    logic           w_clr;

    exec_state_t    r_state;
    logic [2:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [MCW-1:0] r_cnt;
    logic [2*W-1:0] r_result;
    logic           r_done;
    logic           r_ready;

    assign w_din    = '{op: bus.op, a: bus.a, b: bus.b};
    assign w_push   = bus.valid && !alu_rst;
    assign w_finish = (r_state == S_EXEC1) || (r_state == S_MULW && r_cnt == '0);
    // issue overlaps completion so single-cycle ops stream at one per cycle
    assign w_pop    = !alu_rst && !w_empty && ((r_state == S_IDLE) || w_finish);
    assign w_flush  = w_pop && (w_head.op == rst_op);
    assign w_clr    = alu_rst || w_flush;

    alu_in_sync_fifo #(
        .WIDTH ($bits(alu_in_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_din        (w_din),
        .o_dout       (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= no_op;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else if (alu_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            // one slot of slack: the initiator acts on ready a cycle late
            r_ready <= (w_count_next <= CW'(FIFO_DEPTH - 2));
            if (w_finish && op_has_result(r_op)) begin
                r_result <= alu_eval(r_op, r_a, r_b);
                r_done   <= 1'b1;
            end
            if (r_state == S_FLUSH) r_result <= '0;
            if (r_state == S_MULW && r_cnt != '0) r_cnt <= r_cnt - MCW'(1);
            if (w_pop) begin
                r_op <= w_head.op;
                r_a  <= w_head.a;
                r_b  <= w_head.b;
                case (w_head.op)
                    mul_op: begin
                        r_state <= S_MULW;
                        r_cnt   <= MCW'(MUL_LATENCY - 1);
                    end
                    rst_op:  r_state <= S_FLUSH;
                    default: r_state <= S_EXEC1;
                endcase
            end else if (w_finish || r_state == S_FLUSH) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign bus.ready  = r_ready;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.busy   = (w_count != '0) || (r_state != S_IDLE);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && w_full && !w_pop && !w_clr));
endmodule

// File: tb/tb_alu_in_responder_core.sv
// tb/tb_alu_in_responder_core.sv - directed-vector bench for alu_in_responder_core
module tb_alu_in_responder_core;
    import alu_core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_rst = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [15:0] done_q [$];

    always #5 clk = ~clk;

    alu_in_responder_core_if #(.W(8)) bus ();

    alu_in_responder_core #(
        .ALU_IN_OP_WIDTH (8),
        .FIFO_DEPTH      (4),
        .MUL_LATENCY     (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .alu_rst (alu_rst),
        .bus     (bus)
    );

    always @(negedge clk) if (rst && bus.done === 1'b1) done_q.push_back(bus.result);

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        bus.valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.valid = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.ready, bus.done, bus.result, bus.busy} !== 19'd0) begin
            n_miss++; $display("FAIL reset_outputs got %b want 0", {bus.ready, bus.done, bus.result, bus.busy});
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.ready !== 1'b1) begin n_miss++; $display("FAIL ready_after_reset got %b want 1", bus.ready); end
    endtask

    task automatic test_add();
        done_q.delete();
        send(add_op, 8'hFF, 8'h01);
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b0) begin n_miss++; $display("FAIL add_early_done got %b want 0", bus.done); end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0100) begin
            n_miss++; $display("FAIL add_result got done=%b res=%h want done=1 res=0100", bus.done, bus.result);
        end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b0 || bus.result !== 16'h0100) begin
            n_miss++; $display("FAIL add_pulse_hold got done=%b res=%h want done=0 res=0100", bus.done, bus.result);
        end
    endtask

    task automatic test_mul_xor();
        done_q.delete();
        send(mul_op, 8'hFF, 8'hFF);
        send(xor_op, 8'hA5, 8'h0F);
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b0) begin n_miss++; $display("FAIL mul_early_done got %b want 0", bus.done); end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b1 || bus.result !== 16'hFE01) begin
            n_miss++; $display("FAIL mul_result got done=%b res=%h want done=1 res=fe01", bus.done, bus.result);
        end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b1 || bus.result !== 16'h00AA) begin
            n_miss++; $display("FAIL xor_result got done=%b res=%h want done=1 res=00aa", bus.done, bus.result);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (done_q.size() != 2) begin n_miss++; $display("FAIL mul_xor_pulses got %0d want 2", done_q.size()); end
    endtask

    task automatic test_stream();
        logic [2:0]  s_op  [6];
        logic [7:0]  s_a   [6];
        logic [7:0]  s_b   [6];
        logic [15:0] s_exp [6];
        int   sent = 0;
        logic saw_low = 1'b0;
        s_op  = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        s_a   = '{8'hF0, 8'hFF, 8'h12, 8'h80, 8'h0F, 8'h07};
        s_b   = '{8'h3C, 8'hFF, 8'h34, 8'h02, 8'h0F, 8'h09};
        s_exp = '{16'h0030, 16'hFE01, 16'h03A8, 16'h0100, 16'h00E1, 16'h003F};
        done_q.delete();
        for (int c = 0; c < 40; c++) begin
            if (bus.ready !== 1'b1) saw_low = 1'b1;
            if (sent < 6 && bus.ready === 1'b1) begin
                bus.valid = 1'b1; bus.op = s_op[sent]; bus.a = s_a[sent]; bus.b = s_b[sent];
                sent++;
            end else begin
                bus.valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.valid = 1'b0;
        n_vec++;
        if (sent != 6 || saw_low !== 1'b1) begin
            n_miss++; $display("FAIL stream_ready got sent=%0d saw_low=%b want 6 1", sent, saw_low);
        end
        n_vec++;
        if (done_q.size() != 6) begin
            n_miss++; $display("FAIL stream_count got %0d want 6", done_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (done_q[i] !== s_exp[i]) begin
                    n_miss++; $display("FAIL stream_result[%0d] got %h want %h", i, done_q[i], s_exp[i]);
                end
            end
        end
    endtask

    task automatic test_alu_rst();
        done_q.delete();
        send(mul_op, 8'h02, 8'h03);
        send(add_op, 8'h01, 8'h01);
        send(add_op, 8'h02, 8'h02);
        alu_rst = 1'b1;
        bus.valid = 1'b1; bus.op = add_op; bus.a = 8'h05; bus.b = 8'h05;
        @(negedge clk);
        alu_rst = 1'b0; bus.valid = 1'b0;
        n_vec++;
        if ({bus.ready, bus.done, bus.result, bus.busy} !== 19'd0) begin
            n_miss++; $display("FAIL alu_rst_outputs got %b want 0", {bus.ready, bus.done, bus.result, bus.busy});
        end
        @(negedge clk);
        n_vec++;
        if (bus.ready !== 1'b1) begin n_miss++; $display("FAIL alu_rst_ready got %b want 1", bus.ready); end
        send(add_op, 8'h10, 8'h10);
        @(negedge clk);
        alu_rst = 1'b1;
        @(negedge clk);
        alu_rst = 1'b0;
        repeat (6) @(negedge clk);
        n_vec++;
        if (done_q.size() != 0 || bus.result !== 16'h0000 || bus.busy !== 1'b0) begin
            n_miss++; $display("FAIL alu_rst_quiet got pulses=%0d res=%h busy=%b want 0 0000 0",
                               done_q.size(), bus.result, bus.busy);
        end
    endtask

    task automatic test_rst_op();
        done_q.delete();
        send(mul_op, 8'h03, 8'h05);
        send(rst_op, 8'h00, 8'h00);
        send(add_op, 8'h01, 8'h01);
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b1 || bus.result !== 16'h000F) begin
            n_miss++; $display("FAIL rst_op_mul got done=%b res=%h want done=1 res=000f", bus.done, bus.result);
        end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
            n_miss++; $display("FAIL rst_op_clear got done=%b res=%h want done=0 res=0000", bus.done, bus.result);
        end
        repeat (6) @(negedge clk);
        n_vec++;
        if (done_q.size() != 1 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
            n_miss++; $display("FAIL rst_op_flush got pulses=%0d busy=%b ready=%b want 1 0 1",
                               done_q.size(), bus.busy, bus.ready);
        end
    endtask

    task automatic test_noop();
        send(add_op, 8'h12, 8'h34);
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.result !== 16'h0046) begin n_miss++; $display("FAIL noop_setup got %h want 0046", bus.result); end
        done_q.delete();
        send(no_op, 8'h11, 8'h22);
        send(3'b101, 8'h33, 8'h44);
        n_vec++;
        if (bus.busy !== 1'b1) begin n_miss++; $display("FAIL noop_busy got %b want 1", bus.busy); end
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL noop_idle got %b want 0", bus.busy); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_q.size() != 0 || bus.result !== 16'h0046) begin
            n_miss++; $display("FAIL noop_no_done got pulses=%0d res=%h want 0 0046", done_q.size(), bus.result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_xor();
        test_stream();
        test_alu_rst();
        test_rst_op();
        test_noop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/alu_in_responder_core.md
Name: alu_in_responder_core

Overview:
- Synthesizable receiving end of the alu_in interface: presents ready, accepts valid/op/a/b transfers, buffers them in order and executes them.
- Returns each result with a one-cycle done pulse.
- Sits as the ALU datapath behind the alu_in bus and is the DUT that the alu_in initiator BFM drives.

Parameters:
- ALU_IN_OP_WIDTH, 8: operand width W; result width is 2*W.
- FIFO_DEPTH, 4: input buffer entries; minimum 2, power of two.
- MUL_LATENCY, 3: cycles from issue to registered result for mul_op; minimum 1.

Ports:
- clk  input  1  Clock; all logic on rising edge.
- rst  input  1  Reset, asynchronous, active-low.
- alu_rst  input  1  Synchronous soft reset, active-high.
- valid  input  1  Transfer strobe; sampled at rising edge.
- op  input  3  Operation code, alu_in_op_t.
- a  input  W  Operand A.
- b  input  W  Operand B.
- ready  output  1  Registered; high means one further transfer may be presented.
- done  output  1  One-cycle pulse; result is valid.
- result  output  2W  Registered result; holds its value between done pulses.
- busy  output  1  High while the FIFO is non-empty or an operation is executing.

Behaviour:
- Reset (rst low, asynchronous): ready=0, done=0, result=0, busy=0; FIFO emptied; exec unit idle.
- First rising edge after rst release: ready=1.
- Opcodes: no_op=3'b000, add_op=3'b001, and_op=3'b010, xor_op=3'b011, mul_op=3'b100, rst_op=3'b111. Codes 101 and 110 are treated as no_op.
- Accept rule: any edge with valid=1 and alu_rst=0 writes {op,a,b} into the FIFO unconditionally. The core never drops or back-pressures a strobe already presented.
- Ready rule: ready is registered as (entries after this edge) <= FIFO_DEPTH-2. This leaves one slot of slack, because the initiator samples ready one cycle before its valid lands.
- Overflow is therefore impossible under protocol. A write to a full FIFO is dropped and flagged by a simulation-only assertion.
- Issue: when the exec unit is idle and the FIFO is non-empty, the head is popped and captured into exec registers at an edge.
- Issue may occur on the same edge that completes the previous op, so back-to-back single-cycle ops sustain 1 op/cycle.
- Latency, from empty and idle: valid sampled at edge N, issue at N+1, then:
  - add/and/xor: result and done registered at N+2.
  - mul: result and done registered at N+1+MUL_LATENCY.
- Arithmetic, all zero-extended to 2W:
  - add: {carry,sum} = a+b.
  - and: a&b.
  - xor: a^b.
  - mul: full unsigned product a*b.
- no_op: popped and consumes one exec cycle; no done; result unchanged.
- rst_op: acts when it reaches issue, not at acceptance. On issue it flushes all remaining FIFO entries and any in-flight op, clears result to 0, and produces no done. ready follows the ready rule on the next edge.
- alu_rst=1 at an edge: same effect as rst (FIFO empty, exec idle, done=0, result=0, ready=0). A simultaneous valid is discarded.
  - alu_rst wins over completion: no done is issued for an op finishing on that edge.
  - ready returns to 1 on the first edge with alu_rst=0.
- Simultaneous FIFO push and pop: count unchanged; head and tail pointers wrap modulo FIFO_DEPTH.
- Ordering: strictly in order; one op executes at a time, with no overlap of mul with later ops.
- Exec state machine:
  - IDLE -> EXEC1 on a pop of add/and/xor/no_op.
  - IDLE -> MULW on a pop of mul; MULW counts MUL_LATENCY-1 further cycles.
  - IDLE -> FLUSH on a pop of rst_op; FLUSH -> IDLE after one cycle.
  - EXEC1 and MULW completion return to IDLE, or to the next op directly when the FIFO is non-empty.

Decomposition:
- Shared package alu_core_pkg holds:
  - alu_in_op_t enum and opcode constants.
  - Exec state enum.
  - A packed struct {op,a,b} for FIFO entries.
- Sub-module alu_in_sync_fifo: parameterized width/depth; push/pop; count, full and empty outputs; synchronous clear driven by alu_rst or rst_op flush; async active-low rst.
- Exec FSM and datapath live in the top block.

Test Plan (W=8, FIFO_DEPTH=4, MUL_LATENCY=3):
1. Hold rst low 3 cycles, then release -> ready/done/result/busy all 0 during reset; ready=1 at the first edge after release.
2. add a=8'hFF b=8'h01 at edge N -> done high for exactly one cycle at N+2; result=16'h0100.
3. mul a=8'hFF b=8'hFF, then xor a=8'hA5 b=8'h0F -> done at N+4 with result 16'hFE01; next done with result 16'h00AA; exactly two done pulses.
4. Initiator streams 6 transfers (and 8'hF0&8'h3C first, rest mul) at maximum rate -> ready drops while ≥3 entries are held; no assertion fires; 6 done pulses in order, first result 16'h0030.
5. Queue mul, add, add, then pulse alu_rst during the mul -> no done pulses; result=0; ready=1 one edge after alu_rst falls. Repeat using rst_op queued behind a mul -> only the mul result appears; entries after rst_op produce no done.
6. no_op, and undefined op 3'b101 -> busy pulses; no done; result keeps its prior value.
